// File: rtl/video_pkg.sv
// Shared types and default widths for the DE-based video decoder.
package video_pkg;

   typedef enum logic [1:0] {
      ST_SEEK,
      ST_ACTIVE,
      ST_HBLANK,
      ST_VBLANK
   } de_state_t;

   localparam int DEF_BLANK_THRESHOLD = 1024;
   localparam int DEF_POS_WIDTH       = 11;
   localparam int DEF_DATA_WIDTH      = 24;

endpackage

// File: rtl/video_sync2.sv
// Two-flop synchronizer for a bundle of asynchronous inputs. 2-cycle latency,
// all bits share one depth so they stay mutually aligned. No backpressure.
module video_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] async_bits,
   output logic [WIDTH-1:0] sync_bits
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         meta      <= '0;
         sync_bits <= '0;
      end else begin
         meta      <= async_bits;
         sync_bits <= meta;
      end
   end

endmodule

// File: rtl/video_de_decoder.sv
// Recovers pixels, positions and frame geometry from an async pixel clock + DE stream.
// Pixel strobe 3 i_clock cycles after the edge sampling i_vga_clock high; no backpressure.
module video_de_decoder
   import video_pkg::*;
#(
   parameter int BLANK_THRESHOLD = DEF_BLANK_THRESHOLD,
   parameter int POS_WIDTH       = DEF_POS_WIDTH,
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_vga_clock,
   input  logic                  i_data_enable,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_pixel_valid,
   output logic [DATA_WIDTH-1:0] o_pixel,
   output logic [POS_WIDTH-1:0]  o_pos_x,
   output logic [POS_WIDTH-1:0]  o_pos_y,
   output logic                  o_frame_start,
   output logic [POS_WIDTH-1:0]  o_width,
   output logic [POS_WIDTH-1:0]  o_height,
   output logic                  o_locked,
   output logic                  o_error
);

   localparam int CNT_W = $clog2(BLANK_THRESHOLD + 1);
   localparam logic [CNT_W-1:0] THR = CNT_W'(BLANK_THRESHOLD);

   logic [DATA_WIDTH+1:0] sync_bits;
   logic                  s_vclk;
   logic                  s_de;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  vclk_hist;
   logic                  tick;
   logic                  tick_q;
   logic                  de_q;
   logic [DATA_WIDTH-1:0] data_q;

   de_state_t             state, state_nxt;
   logic [POS_WIDTH-1:0]  x_cnt, x_nxt, x_inc;
   logic [POS_WIDTH-1:0]  y_cnt, y_nxt, y_inc;
   logic [CNT_W-1:0]      blank_cnt, blank_nxt, blank_inc;
   logic [POS_WIDTH-1:0]  line_w;

   logic                  emit;
   logic                  first;
   logic [POS_WIDTH-1:0]  emit_x;
   logic [POS_WIDTH-1:0]  emit_y;
   logic                  line_end;
   logic                  frame_end;

   video_sync2 #(.WIDTH(DATA_WIDTH + 2)) u_sync (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .async_bits ({i_vga_clock, i_data_enable, i_data}),
      .sync_bits  (sync_bits)
   );

   assign s_vclk = sync_bits[DATA_WIDTH+1];
   assign s_de   = sync_bits[DATA_WIDTH];
   assign s_data = sync_bits[DATA_WIDTH-1:0];
   assign tick   = s_vclk & ~vclk_hist;

   assign x_inc     = (&x_cnt) ? x_cnt : x_cnt + POS_WIDTH'(1);
   assign y_inc     = (&y_cnt) ? y_cnt : y_cnt + POS_WIDTH'(1);
   assign blank_inc = (blank_cnt == THR) ? blank_cnt : blank_cnt + CNT_W'(1);

   always_ff @(posedge i_clock) begin
      if (i_reset) state <= ST_SEEK;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      x_nxt     = x_cnt;
      y_nxt     = y_cnt;
      blank_nxt = blank_cnt;
      emit      = 1'b0;
      first     = 1'b0;
      emit_x    = '0;
      emit_y    = '0;
      line_end  = 1'b0;
      frame_end = 1'b0;
      if (tick_q) begin
         case (state)
            ST_SEEK: begin
               if (de_q) begin
                  blank_nxt = '0;
               end else begin
                  blank_nxt = blank_inc;
                  if (blank_inc == THR) state_nxt = ST_VBLANK;
               end
            end
            ST_VBLANK: begin
               if (de_q) begin
                  emit      = 1'b1;
                  first     = 1'b1;
                  x_nxt     = POS_WIDTH'(1);
                  y_nxt     = '0;
                  blank_nxt = '0;
                  state_nxt = ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (de_q) begin
                  emit   = 1'b1;
                  emit_x = x_cnt;
                  emit_y = y_cnt;
                  x_nxt  = x_inc;
               end else begin
                  line_end  = 1'b1;
                  blank_nxt = CNT_W'(1);
                  state_nxt = ST_HBLANK;
               end
            end
            ST_HBLANK: begin
               // Threshold already reached on entry: close the frame and keep this tick's pixel.
               if (blank_cnt == THR) begin
                  frame_end = 1'b1;
                  blank_nxt = '0;
                  if (de_q) begin
                     emit      = 1'b1;
                     first     = 1'b1;
                     x_nxt     = POS_WIDTH'(1);
                     y_nxt     = '0;
                     state_nxt = ST_ACTIVE;
                  end else begin
                     state_nxt = ST_VBLANK;
                  end
               end else if (de_q) begin
                  emit      = 1'b1;
                  emit_y    = y_inc;
                  x_nxt     = POS_WIDTH'(1);
                  y_nxt     = y_inc;
                  blank_nxt = '0;
                  state_nxt = ST_ACTIVE;
               end else begin
                  blank_nxt = blank_inc;
                  if (blank_inc == THR) begin
                     frame_end = 1'b1;
                     state_nxt = ST_VBLANK;
                  end
               end
            end
            default: state_nxt = ST_SEEK;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         vclk_hist     <= 1'b0;
         tick_q        <= 1'b0;
         de_q          <= 1'b0;
         data_q        <= '0;
         x_cnt         <= '0;
         y_cnt         <= '0;
         blank_cnt     <= '0;
         line_w        <= '0;
         o_pixel_valid <= 1'b0;
         o_pixel       <= '0;
         o_pos_x       <= '0;
         o_pos_y       <= '0;
         o_frame_start <= 1'b0;
         o_width       <= '0;
         o_height      <= '0;
         o_locked      <= 1'b0;
         o_error       <= 1'b0;
      end else begin
         vclk_hist     <= s_vclk;
         tick_q        <= tick;
         de_q          <= s_de;
         data_q        <= s_data;
         x_cnt         <= x_nxt;
         y_cnt         <= y_nxt;
         blank_cnt     <= blank_nxt;
         o_pixel_valid <= emit;
         o_frame_start <= first;
         if (emit) begin
            o_pixel <= data_q;
            o_pos_x <= emit_x;
            o_pos_y <= emit_y;
         end
         if (line_end) begin
            line_w <= x_cnt;
            if (o_locked && (x_cnt != o_width)) o_error <= 1'b1;
         end
         if (frame_end) begin
            if ((line_w == o_width) && (y_inc == o_height)) begin
               o_locked <= 1'b1;
            end else begin
               o_locked <= 1'b0;
               o_error  <= 1'b0;
            end
            o_width  <= line_w;
            o_height <= y_inc;
         end
      end
   end

endmodule
